// File: rtl/serial_subtractor_pkg.sv
// rtl/serial_subtractor_pkg.sv - shared constants and state encoding for the bit-serial subtractor
//
// Purpose : state encoding and default operand width shared by the
//           serial_subtractor top and its testbench.
// Ports   : none (package).
package serial_subtractor_pkg;

  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/serial_subtractor_full_subtractor1.sv
// rtl/serial_subtractor_full_subtractor1.sv - 1-bit full-subtractor cell built from gate primitives
//
// Purpose : combinational cell computing d = a - b - bi with borrow-out bo.
// Ports   : d  (out) difference bit
//           bo (out) borrow out
//           a  (in)  minuend bit
//           b  (in)  subtrahend bit
//           bi (in)  borrow in
module full_subtractor1 (
  output logic d,
  output logic bo,
  input  logic a,
  input  logic b,
  input  logic bi
);

  wire a_x_b;
  wire a_n;
  wire axb_n;
  wire brw_ab;
  wire brw_in;

  // d = a ^ b ^ bi
  xor g_x0 (a_x_b, a, b);
  xor g_x1 (d, a_x_b, bi);

  // bo = (~a & b) | (~(a ^ b) & bi)
  not g_n0 (a_n, a);
  not g_n1 (axb_n, a_x_b);
  and g_a0 (brw_ab, a_n, b);
  and g_a1 (brw_in, axb_n, bi);
  or  g_o0 (bo, brw_ab, brw_in);

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial two's-complement subtractor with start/ready and valid/ack handshakes
//
// Purpose : computes D = A - B - BIN one bit per clock, LSB first, over
//           WIDTH cycles using a single full-subtractor cell and a borrow
//           flip-flop.
// Ports   : clk   (in)  clock, rising edge
//           rst   (in)  synchronous active-high reset
//           start (in)  begin operation, accepted only while ready
//           A     (in)  minuend, captured on accepted start
//           B     (in)  subtrahend, captured on accepted start
//           BIN   (in)  initial borrow, captured on accepted start
//           ready (out) high in IDLE
//           valid (out) high in DONE; D/BOUT/OVF meaningful
//           ack   (in)  consumer acknowledge, honoured in DONE only
//           D     (out) difference
//           BOUT  (out) final borrow out (unsigned A < B+BIN)
//           OVF   (out) signed overflow
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             BIN,
  output logic             ready,
  output logic             valid,
  input  logic             ack,
  output logic [WIDTH-1:0] D,
  output logic             BOUT,
  output logic             OVF
);

  localparam int                CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e             state_q;
  logic               ready_q;
  logic               valid_q;
  logic [WIDTH-1:0]   sa_q;
  logic [WIDTH-1:0]   sb_q;
  logic [WIDTH-1:0]   sd_q;
  logic [WIDTH-1:0]   sd_d;
  logic               borrow_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               a_msb_q;
  logic               b_msb_q;
  logic [WIDTH-1:0]   d_q;
  logic               bout_q;
  logic               ovf_q;
  logic               ovf_d;

  logic               cell_d;
  logic               cell_bo;

  full_subtractor1 u_cell (
    .d  (cell_d),
    .bo (cell_bo),
    .a  (sa_q[0]),
    .b  (sb_q[0]),
    .bi (borrow_q)
  );

  // The new difference bit enters at the MSB, so after WIDTH shifts the
  // first (LSB) result bit has arrived at bit 0.
  always_comb begin
    sd_d  = {cell_d, sd_q[WIDTH-1:1]};
    // On the final edge cell_d is the result MSB; only the captured operand
    // sign bits matter, not whatever is left in the shift registers.
    ovf_d = (a_msb_q ^ b_msb_q) & (cell_d ^ a_msb_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      ready_q  <= 1'b1;
      valid_q  <= 1'b0;
      sa_q     <= '0;
      sb_q     <= '0;
      sd_q     <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      d_q      <= '0;
      bout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            sa_q     <= A;
            sb_q     <= B;
            borrow_q <= BIN;
            a_msb_q  <= A[WIDTH-1];
            b_msb_q  <= B[WIDTH-1];
            cnt_q    <= '0;
            state_q  <= ST_RUN;
            ready_q  <= 1'b0;
          end
        end

        ST_RUN: begin
          sa_q     <= sa_q >> 1;
          sb_q     <= sb_q >> 1;
          sd_q     <= sd_d;
          borrow_q <= cell_bo;
          if (cnt_q == CNT_LAST) begin
            // Counter stops here; it is reloaded on the next accepted start.
            state_q <= ST_DONE;
            valid_q <= 1'b1;
            d_q     <= sd_d;
            bout_q  <= cell_bo;
            ovf_q   <= ovf_d;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        ST_DONE: begin
          // start is deliberately not looked at here, even alongside ack.
          if (ack) begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
          end
        end

        default: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b1;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign ready = ready_q;
  assign valid = valid_q;
  assign D     = d_q;
  assign BOUT  = bout_q;
  assign OVF   = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - self-checking bench for serial_subtractor
module tb_serial_subtractor;
  import serial_subtractor_pkg::*;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         BIN;
  logic         ready;
  logic         valid;
  logic         ack;
  logic [W-1:0] D;
  logic         BOUT;
  logic         OVF;

  int n_cmp;
  int n_bad;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .BIN   (BIN),
    .ready (ready),
    .valid (valid),
    .ack   (ack),
    .D     (D),
    .BOUT  (BOUT),
    .OVF   (OVF)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue start, count edges until valid (bounded), return edge count.
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                        output int edges);
    start = 1'b1; A = a; B = b; BIN = bin;
    tick();
    start = 1'b0;
    A = ~a; B = ~b; BIN = ~bin;   // later operand changes must not matter
    chk("ready_low_run", ready, 0);
    edges = 0;
    while (!valid && edges < 40) begin
      if (edges > 0) chk("ready_low_wait", ready, 0);
      tick();
      edges++;
    end
  endtask

  task automatic check_result(input string tag, input logic [W-1:0] ed,
                              input logic eb, input logic eo);
    chk({tag, "_valid"}, valid, 1);
    chk({tag, "_ready"}, ready, 0);
    chk({tag, "_D"}, D, ed);
    chk({tag, "_BOUT"}, BOUT, eb);
    chk({tag, "_OVF"}, OVF, eo);
  endtask

  task automatic finish_ack(input int delay);
    for (int i = 0; i < delay; i++) tick();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("ack_valid_low", valid, 0);
    chk("ack_ready_high", ready, 1);
  endtask

  task automatic directed(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic bin, input logic [W-1:0] ed, input logic eb, input logic eo);
    int e;
    launch(a, b, bin, e);
    chk({tag, "_latency"}, e, W);
    check_result(tag, ed, eb, eo);
    finish_ack(0);
  endtask

  initial begin
    int e;
    logic [W:0]   diff;
    logic [W-1:0] ra, rb, ed;
    logic         rbin, eo;

    n_cmp = 0; n_bad = 0;
    rst = 1'b1; start = 1'b0; A = '0; B = '0; BIN = 1'b0; ack = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_ready", ready, 1);
    chk("rst_valid", valid, 0);
    chk("rst_D", D, 0);
    chk("rst_BOUT", BOUT, 0);
    chk("rst_OVF", OVF, 0);

    // ack in IDLE is ignored
    ack = 1'b1; tick(); ack = 1'b0;
    chk("idle_ack_ready", ready, 1);

    directed("v35m12", 8'h35, 8'h12, 1'b0, 8'h23, 1'b0, 1'b0);
    chk("hold_after_ack_D", D, 8'h23);
    directed("v12m35", 8'h12, 8'h35, 1'b0, 8'hDD, 1'b1, 1'b0);
    directed("v00m00b", 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0);
    directed("v80m01", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
    directed("v7FmFF", 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1);

    // start and ack pulsed mid-RUN are ignored
    start = 1'b1; A = 8'h35; B = 8'h12; BIN = 1'b0;
    tick();
    start = 1'b0;
    tick(); tick();
    start = 1'b1; A = 8'hAA; B = 8'h01; BIN = 1'b1; ack = 1'b1;
    tick();
    start = 1'b0; ack = 1'b0;
    chk("run_start_ignored_ready", ready, 0);
    e = 3;
    while (!valid && e < 40) begin tick(); e++; end
    chk("run_start_latency", e, W);
    check_result("run_start", 8'h23, 1'b0, 1'b0);

    // hold in DONE with ack low, start pulsed in DONE
    for (int i = 0; i < 5; i++) begin
      start = (i == 2);
      A = 8'h01; B = 8'h02;
      tick();
      chk("hold_valid", valid, 1);
      chk("hold_D", D, 8'h23);
    end
    start = 1'b0;

    // ack and start together in DONE: IDLE only
    ack = 1'b1; start = 1'b1; A = 8'h55; B = 8'h11;
    tick();
    ack = 1'b0; start = 1'b0;
    chk("ackstart_ready", ready, 1);
    chk("ackstart_valid", valid, 0);
    tick();
    chk("ackstart_no_new_op", ready, 1);
    chk("ackstart_D_held", D, 8'h23);

    // reset at cnt=4 aborts
    start = 1'b1; A = 8'h12; B = 8'h35; BIN = 1'b0;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_ready", ready, 1);
    chk("midrst_valid", valid, 0);
    chk("midrst_D", D, 0);
    chk("midrst_BOUT", BOUT, 0);
    chk("midrst_OVF", OVF, 0);
    directed("after_rst", 8'h35, 8'h12, 1'b0, 8'h23, 1'b0, 1'b0);

    // back-to-back random operations against A-B-BIN
    for (int k = 0; k < 200; k++) begin
      ra   = W'($urandom);
      rb   = W'($urandom);
      rbin = 1'($urandom);
      diff = {1'b0, ra} - {1'b0, rb} - {{W{1'b0}}, rbin};
      ed   = diff[W-1:0];
      eo   = (ra[W-1] != rb[W-1]) && (ed[W-1] != ra[W-1]);
      launch(ra, rb, rbin, e);
      chk("rnd_latency", e, W);
      chk("rnd_D", D, ed);
      chk("rnd_BOUT", BOUT, diff[W]);
      chk("rnd_OVF", OVF, eo);
      finish_ack(int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
